vga_frame_streamer: RTL
=======================

Name: vga_frame_streamer

Overview:
- Transmit side of the video-memory write interface: streams one full frame out of a source image buffer as a `start` pulse, NUM_PIX `we`/`wdata` beats, then a `done` pulse.
- The VGA driver's DMA consumes that stream and fills video memory.
- Sits between the image-coprocessor result buffer (synchronous-read RAM, 1-cycle latency) and the VGA driver's write port.
- Launched by a single-cycle `go` from the CPU/coprocessor control logic.

Parameters:
- ADDR_W, 16, width of the source buffer read address.
- DATA_W, 12, pixel width (4:4:4 RGB).
- NUM_PIX, 65536, pixels per frame (256x256); must be >= 2 and <= 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  frame request pulse; sampled only in IDLE.
- pause  input  1  while high, no new source reads are issued.
- src_re  output  1  source buffer read enable.
- src_raddr  output  ADDR_W  source buffer read address.
- src_rdata  input  DATA_W  source read data, valid the cycle after src_re.
- start  output  1  one-cycle frame-start pulse to the VGA driver.
- we  output  1  pixel write strobe to the VGA driver.
- wdata  output  DATA_W  pixel data; valid when we=1.
- done  output  1  one-cycle frame-complete pulse.
- busy  output  1  high from the start cycle through the done cycle inclusive.

Behaviour:
- Clock and reset: one clock (`clk`); reset `rst` is synchronous and active-high.
- Reset: state=IDLE; read counter=0; start, we, done, busy, src_re=0; src_raddr=0; wdata=0.
- FSM states: IDLE, START, STREAM, DRAIN, FIN.
- IDLE: go=1 -> START; otherwise stay. go is ignored in every other state; there is no queuing.
- START: start=1 and busy=1 for exactly this cycle -> STREAM.
- STREAM, issue rule: src_re = !pause; src_raddr = read counter. The counter increments on each issued read.
  - When a read issues with counter = NUM_PIX-1 -> DRAIN.
  - Otherwise stay in STREAM.
- Write timing: we is src_re registered one cycle. wdata is src_rdata when we=1, else held at 0. This gives fixed 1-cycle read-to-write latency.
- DRAIN: no read issued; emits the final we beat -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- busy deasserts in the cycle after FIN.
- Timing with go at cycle T and no pause:
  - start at T+1.
  - src_re T+2..T+NUM_PIX+1.
  - we T+3..T+NUM_PIX+2.
  - done at T+NUM_PIX+3.
- Pause:
  - pause rising in cycle N suppresses the read in N.
  - A read issued in N-1 still produces its we in N; in-flight data is never dropped.
  - Pause in DRAIN or FIN has no effect.
  - Beats are never duplicated or skipped; addresses are strictly 0..NUM_PIX-1 in order.
- Counter: width ADDR_W+1 bits so that NUM_PIX = 2^ADDR_W does not alias. src_raddr is its low ADDR_W bits.
- Exactly NUM_PIX we beats occur between start and done.
- start, we and done are mutually exclusive in every cycle.
- rst mid-frame: on the next edge, return to IDLE with all outputs 0. No done is emitted; a partial frame is abandoned.
- go coincident with rst: rst wins.
- go in the FIN cycle: ignored. A new go is accepted from the first IDLE cycle.

Test Plan:
- Reset/idle (NUM_PIX=16): hold rst 3 cycles, go=0 -> all outputs 0, no src_re for 20 cycles.
- Basic frame (NUM_PIX=16): buffer mem[i]=12'h100+i, go at T.
  - start at T+1.
  - we T+3..T+18 with wdata 12'h100..12'h10F in order.
  - done at T+19; busy high T+1..T+19.
- Pause (NUM_PIX=16):
  - pause high for 5 cycles starting at the 4th read -> exactly 16 beats, data 12'h100..12'h10F, no gaps in sequence.
  - done delayed by 5 cycles to T+24.
- Mid-frame reset (NUM_PIX=16): rst asserted after 7th we -> next cycle all outputs 0, no done. A new go yields a full frame starting at address 0.
- Ignored go (NUM_PIX=16): go pulses during STREAM and FIN -> exactly one start/done pair per accepted go.
- Full size (NUM_PIX=65536, random pause 25%): count of we = 65536; last wdata = mem[65535]; src_raddr wraps from 16'hFFFF without an extra read; done once.

Source files
------------

// File: rtl/vga_frame_streamer.sv
// vga_frame_streamer: streams one frame from a sync-read source buffer to the VGA driver write port as start, NUM_PIX we/wdata beats, done
//   clk, rst            clock, synchronous active-high reset
//   go                  frame request pulse, accepted only in IDLE
//   pause               holds off new source reads while high
//   src_re/src_raddr    source buffer read request
//   src_rdata           source data, valid the cycle after src_re
//   start/we/wdata/done frame stream to the VGA driver
//   busy                high from the start cycle through the done cycle
module vga_frame_streamer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12,
  parameter int NUM_PIX = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              pause,
  output logic              src_re,
  output logic [ADDR_W-1:0] src_raddr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              start,
  output logic              we,
  output logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, FIN} state_t;
  localparam int unsigned LAST_I = NUM_PIX - 1;
  localparam logic [ADDR_W:0] LAST = LAST_I[ADDR_W:0];
  state_t r_state, w_next;
  // one extra bit so a full 2^ADDR_W frame does not alias back to zero
  logic [ADDR_W:0] r_cnt;
  logic r_we;
  always_comb begin
    w_next = r_state;
    src_re = 1'b0;
    start  = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:    w_next = go ? START : IDLE;
      START: begin
        start  = 1'b1;
        w_next = STREAM;
      end
      STREAM: begin
        src_re = !pause;
        w_next = (!pause && r_cnt == LAST) ? DRAIN : STREAM;
      end
      DRAIN:   w_next = FIN;
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  assign busy      = r_state != IDLE;
  assign src_raddr = r_cnt[ADDR_W-1:0];
  assign we        = r_we;
  // the source RAM has one cycle of latency, so its output lines up with the registered strobe
  assign wdata     = r_we ? src_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= src_re;
      r_cnt   <= src_re ? r_cnt + 1'b1 : (r_state == FIN ? '0 : r_cnt);
    end
  end
endmodule
